mips_data_memory: RTL

MIPS_DATA_MEMORY -- requirements
Module: mips_data_memory

---
 rtl/mips_data_memory.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mips_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : mips_data_memory
// Brief    : Fixed-latency single-port data memory with a valid/ready request
//            and response handshake. Optional macro MIPS_DMEM_ALIGN_CHECK_EN
//            rejects misaligned requests with resp_err.
// Revision : 1.0  initial release
// ============================================================================
module mips_data_memory #(
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] data_memory_a,
    input  logic        data_memory_we,
    input  logic [31:0] data_memory_wd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] data_memory_rd,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         C_DEPTH    = 1 << AW;
    localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic          we_q;
    logic [31:0]   wd_q;
    logic [31:0]   rd_q;
    logic [31:0]   mem_q [C_DEPTH];

    logic          w_accept;
    logic          w_execute;
    logic          w_misaligned;
    logic          w_addr_unused;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)     state_d = S_BUSY;
            S_BUSY:  if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  if (resp_ready)    state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
    end

    assign w_accept  = (state_q == S_IDLE) && req_valid;
    assign w_execute = (state_q == S_BUSY) && (cnt_q == 4'd0);

    // Bits above the word index and the byte lane are intentionally dropped.
    assign w_addr_unused = ^data_memory_a;

    // Request fields are only consumed after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            idx_q <= data_memory_a[AW+1:2];
            we_q  <= data_memory_we;
            wd_q  <= data_memory_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            rd_q  <= 32'd0;
        end else begin
            if (w_accept) begin
                cnt_q <= C_CNT_LOAD;
            end else if ((state_q == S_BUSY) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (w_execute) begin
                rd_q <= (we_q || w_misaligned) ? 32'd0 : mem_q[idx_q];
            end
        end
    end

    // Array has no reset; a reset during BUSY suppresses the pending write.
    always_ff @(posedge clk) begin
        if (rst_n && w_execute && we_q && !w_misaligned) begin
            mem_q[idx_q] <= wd_q;
        end
    end

    assign data_memory_rd = rd_q;

`ifdef MIPS_DMEM_ALIGN_CHECK_EN
    logic misalign_q;
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (w_accept) begin
                misalign_q <= |data_memory_a[1:0];
            end
            if (w_execute) begin
                err_q <= misalign_q;
            end
        end
    end

    assign w_misaligned = misalign_q;
    assign resp_err     = err_q;
`else
    assign w_misaligned = 1'b0;
    assign resp_err     = 1'b0;
`endif

endmodule
`default_nettype wire
